// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the multicycle control unit.
//   state_t  - FSM state encoding (also the 4-bit debug view on the top's state port)
//   OP_*     - RV32I major opcodes recognised by the decoder
//   *_ENC    - field encodings of the datapath mux selects
//   ctrl_t   - control word, fields listed in output order
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE_R = 4'd6,
    S_ALU_WB    = 4'd7,
    S_EXECUTE_I = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I      = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S      = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B      = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J      = 2'b11;

  localparam logic [SEL_W-1:0] ALU_ADD    = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB    = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNCT  = 2'b10;

  typedef struct packed {
    logic             mem_req;
    logic             pc_up;
    logic             branch;
    logic             adr_src;
    logic             mem_wr;
    logic             ir_rd;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] imm_src;
    logic [SEL_W-1:0] alu_op;
    logic             reg_wr;
  } ctrl_t;

  // States in which the FSM waits on the memory handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/cu_control_decoder.sv
// cu_control_decoder: combinational map from FSM state (plus opcode and
// mem_ready) to the datapath control word. Unlisted fields stay 0.
// Configuration macro: CU_JAL_EN (adds the JAL state decode and imm_src=J).
// Ports:
//   state     in  current FSM state
//   opcode    in  instr[6:0] from the IR
//   mem_ready in  memory completes the current access this cycle
//   ctrl      out control word
module cu_control_decoder
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        // IR load and PC+4 only happen in the cycle the fetch completes.
        ctrl.ir_rd      = mem_ready;
        ctrl.pc_up      = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_B;
`ifdef CU_JAL_EN
        if (opcode == OP_JAL) ctrl.imm_src = IMM_J;
`endif
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_req = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_wr     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_req = 1'b1;
        ctrl.mem_wr  = mem_ready;
      end
      S_EXECUTE_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECUTE_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_wr = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
      end
`ifdef CU_JAL_EN
      S_JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_up     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cu_multicycle_ctrl.sv
// cu_multicycle_ctrl: multicycle RISC-V control unit. Holds the state
// register, the memory-wait watchdog and the retired-instruction counter;
// the control word comes from cu_control_decoder.
// Configuration macro: CU_JAL_EN (JAL support; undefined -> JAL is illegal).
// Parameters: TIMEOUT (watchdog limit, 0 disables), CNT_W (retired width).
// Ports:
//   clk, rst_n (sync, active-low)       opcode, funct3, zero, mem_ready in
//   mem_req, pc_wr, adr_src, mem_wr, ir_rd, result_src, alu_src_a,
//   alu_src_b, imm_src, alu_op, reg_wr  datapath controls out
//   state (debug), fault (sticky), retired (wrapping count)  out
//
// state       | meaning
// FETCH       | read instruction at PC, wait for mem_ready
// DECODE      | compute branch/jump target into ALUOut
// MEM_ADR     | compute load/store address
// MEM_READ    | load access, wait for mem_ready
// MEM_WB      | write loaded data to rd
// MEM_WRITE   | store access, wait for mem_ready
// EXECUTE_R   | register-register ALU op
// ALU_WB      | write ALU result to rd
// EXECUTE_I   | register-immediate ALU op
// BRANCH      | compare rs1/rs2, redirect PC if taken
// JAL         | link old PC+4, jump (CU_JAL_EN only)
// FAULT       | illegal opcode or memory timeout, sticky until reset
module cu_multicycle_ctrl
  import cu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_wr,
  output logic             adr_src,
  output logic             mem_wr,
  output logic             ir_rd,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [1:0]       alu_op,
  output logic             reg_wr,
  output logic [3:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state_q, state_nx;
  logic [WD_W-1:0]  wd_cnt, wd_nx;
  logic             wd_hit;
  logic             retire;
  logic             fault_q;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;
  logic             unused_funct3;

  cu_control_decoder u_dec (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Only BEQ/BNE are resolved: funct3[0] inverts the zero test.
  assign unused_funct3 = ^funct3[2:1];

  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT));

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_nx = S_DECODE;
                   else if (wd_hit) state_nx = S_FAULT;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEM_ADR;
          OP_RTYPE:          state_nx = S_EXECUTE_R;
          OP_ITYPE:          state_nx = S_EXECUTE_I;
          OP_BRANCH:         state_nx = S_BRANCH;
`ifdef CU_JAL_EN
          OP_JAL:            state_nx = S_JAL;
`endif
          default:           state_nx = S_FAULT;
        endcase
      end
      S_MEM_ADR:   state_nx = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_nx = S_MEM_WB;
                   else if (wd_hit) state_nx = S_FAULT;
      S_MEM_WB:    state_nx = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_nx = S_FETCH;
                   else if (wd_hit) state_nx = S_FAULT;
      S_EXECUTE_R: state_nx = S_ALU_WB;
      S_EXECUTE_I: state_nx = S_ALU_WB;
      S_ALU_WB:    state_nx = S_FETCH;
      S_BRANCH:    state_nx = S_FETCH;
`ifdef CU_JAL_EN
      S_JAL:       state_nx = S_ALU_WB;
`endif
      default:     state_nx = S_FAULT;
    endcase
  end

  // A timeout forces a state change, so the counter clears on that edge too.
  assign wd_nx = (is_wait_state(state_q) && !mem_ready && (state_nx == state_q))
                 ? wd_cnt + 1'b1 : '0;

  assign retire = (state_nx == S_FETCH) &&
                  ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                   (state_q == S_ALU_WB) || (state_q == S_BRANCH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wd_cnt    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_nx;
      wd_cnt  <= wd_nx;
      fault_q <= fault_q | (state_nx == S_FAULT);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign pc_wr      = ctrl.pc_up | (ctrl.branch & (zero ^ funct3[0]));
  assign adr_src    = ctrl.adr_src;
  assign mem_wr     = ctrl.mem_wr;
  assign ir_rd      = ctrl.ir_rd;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign imm_src    = ctrl.imm_src;
  assign alu_op     = ctrl.alu_op;
  assign reg_wr     = ctrl.reg_wr;
  assign state      = state_q;
  assign fault      = fault_q;
  assign retired    = retired_q;

endmodule

// File: doc/cu_multicycle_ctrl.md
# cu_multicycle_ctrl

Multicycle control unit for the RISC-V core: owns the state register, next-state logic and control-word decode that select the datapath muxes each cycle. It extends the existing decoder with:
- a memory ready handshake, with stall states;
- branch resolution (BEQ/BNE) and an illegal-opcode fault state;
- a memory-wait watchdog and a retired-instruction counter.

It sits between the instruction register/ALU flags and the datapath mux selects.

## Interface
Parameters:
- TIMEOUT, default 16: max cycles waiting on mem_ready before fault. 0 disables the watchdog.
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  instr[6:0] from IR.
- funct3  in  3  instr[14:12] from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- pc_wr  out  1  PC write enable: pc_up | (branch & taken).
- adr_src  out  1  0 = PC, 1 = ALU result register.
- mem_wr  out  1  memory write.
- ir_rd  out  1  IR/old-PC load.
- result_src  out  2  00 ALUOut, 01 data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4.
- imm_src  out  2  00 I, 01 S, 10 B, 11 J.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- reg_wr  out  1  register-file write.
- state  out  4  current state, for debug.
- fault  out  1  sticky fault flag.
- retired  out  CNT_W  retired-instruction count, wraps.

## Operation
- States: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE_R=6, ALU_WB=7, EXECUTE_I=8, BRANCH=9, JAL=10, FAULT=15.
- All unlisted controls are 0. This block drives no don't-cares.
- FETCH: mem_req=1, alu_src_b=10, result_src=10. ir_rd and pc_up assert only when mem_ready=1; the FSM stays in FETCH until then.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10. imm_src=11 when opcode=1101111.
- DECODE next state by opcode:
  - 0000011 or 0100011 → MEM_ADR.
  - 0110011 → EXECUTE_R.
  - 0010011 → EXECUTE_I.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - anything else → FAULT.
- MEM_ADR: alu_src_a=10, alu_src_b=01. imm_src=01 for store, 00 for load. Next state MEM_WRITE for store, MEM_READ for load.
- MEM_READ: adr_src=1, mem_req=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB: result_src=01, reg_wr=1, then → FETCH.
- MEM_WRITE: adr_src=1, mem_req=1. mem_wr=1 only in the mem_ready cycle. Holds until mem_ready, then → FETCH.
- EXECUTE_R: alu_src_a=10, alu_op=10, then → ALU_WB.
- EXECUTE_I: alu_src_a=10, alu_src_b=01, alu_op=10, then → ALU_WB.
- ALU_WB: reg_wr=1, then → FETCH.
- BRANCH: alu_src_a=10, alu_op=01, branch=1, with taken = zero ^ funct3[0]. Then → FETCH.
- JAL: alu_src_a=01, alu_src_b=10, pc_up=1, then → ALU_WB.
- FAULT: all controls 0, fault=1. Sticky until reset.
- Watchdog:
  - The counter increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - It clears on mem_ready or on a state change.
  - When it reaches TIMEOUT, the FSM goes to FAULT on the next edge.
- retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH. It wraps modulo 2^CNT_W.

## Timing
- Reset: rst_n low at a clock edge sets:
  - state=FETCH, retired=0, fault=0, watchdog=0;
  - combinational outputs follow FETCH: mem_req=1, alu_src_b=10, result_src=10.
- Reset mid-instruction aborts with no further writes.
- Controls are Moore outputs of state, except these Mealy terms in the mem_ready cycle: ir_rd, pc_up and mem_wr.
- Minimum cycles per class, with mem_ready tied high: load 5, store 4, R/I 4, branch 3, JAL 4.
- If mem_ready and the watchdog limit coincide, mem_ready wins and the access completes.

## Configuration
- CU_JAL_EN defined: JAL state and opcode 1101111 supported as above.
- CU_JAL_EN undefined:
  - the JAL state is not built;
  - 1101111 decodes as illegal → FAULT;
  - imm_src is never 11.

## Structure
- Shared package cu_pkg holds:
  - state localparams;
  - opcode constants;
  - control-word field widths and order.
- One natural sub-module: cu_control_decoder. It is the combinational map from state, opcode and mem_ready to the control word.
- The top holds the state register, watchdog counter and retired counter.

## Test plan
- Reset, then lw (opcode 0000011) with mem_ready=1 → states 0,1,2,3,4,0; reg_wr=1 in state 4; retired=1.
- sw with mem_ready low for 3 cycles in MEM_WRITE → FSM holds in state 5; mem_wr=1 only in the 4th cycle; retired=1.
- beq (funct3=000) with zero=1 → pc_wr=1 in BRANCH. Same instruction with zero=0 → pc_wr=0.
- opcode 1111111 → FAULT at the cycle after DECODE; fault stays 1 until rst_n=0.
- TIMEOUT=4 and mem_ready held 0 in FETCH → FAULT after 4 wait cycles; pulsing mem_ready at cycle 4 completes the fetch instead.
- Build with and without CU_JAL_EN, opcode 1101111:
  - with the macro → states 1,10,7, pc_wr=1 in JAL;
  - without the macro → FAULT.
